// File: rtl/cal_pkg.sv
// Shared types and month-length logic for the calendar chain.
package cal_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_TIME = 2'd1,
        SET_DATE = 2'd2,
        CLAMP    = 2'd3
    } cal_state_t;

    // 0-based month numbers of the short months
    localparam logic [6:0] FEB = 7'd1;
    localparam logic [6:0] APR = 7'd3;
    localparam logic [6:0] JUN = 7'd5;
    localparam logic [6:0] SEP = 7'd8;
    localparam logic [6:0] NOV = 7'd10;

    // Days in a month; also used by the day counter so the two can never disagree.
    // Out-of-range months fall through to 31.
    function automatic logic [6:0] month_len(input logic [6:0] mon);
        case (mon)
            FEB:                return 7'd28;
            APR, JUN, SEP, NOV: return 7'd30;
            default:            return 7'd31;
        endcase
    endfunction

endpackage

// File: rtl/cal_ctrl_btn_edge.sv
// Multi-flop synchronizer with a rising-edge pulse on its output.
module btn_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the raw input through the chain; prev holds last cycle's synced level.
    // Resetting to RST_VAL=1 keeps a button held through reset from pulsing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign pulse = level & ~prev;

endmodule

// File: rtl/cal_ctrl.sv
// Calendar sequencing controller: run-mode carry cascade, set-mode button
// advance, and a one-cycle day clamp after a manual month change.
module cal_ctrl
    import cal_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sec_z,
    input  logic       min_z,
    input  logic       hr_z,
    input  logic       day_z,
    input  logic [6:0] mon_in,
    input  logic [6:0] day_in,
    input  logic       set_time,
    input  logic       set_date,
    input  logic       min_adv,
    input  logic       hr_adv,
    input  logic       day_adv,
    input  logic       mon_adv,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       day_en,
    output logic       mon_en,
    output logic       sec_clr,
    output logic       day_clr,
    output logic [1:0] mode
);

    cal_state_t state, mode_next;
    logic st_lvl, sd_lvl;
    logic min_p, hr_p, day_p, mon_p;
    logic st_edge_unused, sd_edge_unused;
    logic unused;

    // Mode levels: synchronizer only, start low.
    btn_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_st (
        .clk(clk), .rst(rst), .din(set_time), .level(st_lvl), .pulse(st_edge_unused));
    btn_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sd (
        .clk(clk), .rst(rst), .din(set_date), .level(sd_lvl), .pulse(sd_edge_unused));

    logic [3:0] btn_raw, btn_p, btn_lvl_unused;
    assign btn_raw = {mon_adv, day_adv, hr_adv, min_adv};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_btn (
            .clk(clk), .rst(rst), .din(btn_raw[i]),
            .level(btn_lvl_unused[i]), .pulse(btn_p[i]));
    end

    assign {mon_p, day_p, hr_p, min_p} = btn_p;
    assign unused = ^{st_edge_unused, sd_edge_unused, btn_lvl_unused};

    // Mode selected by the synchronized levels; set_time wins over set_date.
    always_comb begin
        mode_next = RUN;
        if (st_lvl)      mode_next = SET_TIME;
        else if (sd_lvl) mode_next = SET_DATE;
    end

    // State register: a month advance in date-set forces one clamp cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                SET_DATE: state <= mon_p ? CLAMP : mode_next;
                default:  state <= mode_next;
            endcase
        end
    end

    // Enables and clears decoded from state; all held low while in reset.
    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hr_en   = 1'b0;
        day_en  = 1'b0;
        mon_en  = 1'b0;
        sec_clr = 1'b0;
        day_clr = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    sec_en = tick;
                    min_en = tick & sec_z;
                    hr_en  = tick & sec_z & min_z;
                    day_en = tick & sec_z & min_z & hr_z;
                    mon_en = tick & sec_z & min_z & hr_z & day_z;
                end
                SET_TIME: begin
                    sec_clr = 1'b1;
                    min_en  = min_p;
                    hr_en   = hr_p;
                end
                SET_DATE: begin
                    // A month change wins; the day pulse is dropped so the
                    // clamp sees a consistent day value.
                    mon_en = mon_p;
                    day_en = day_p & ~mon_p;
                end
                CLAMP: begin
                    day_clr = (day_in >= month_len(mon_in));
                end
                default: ;
            endcase
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_cal_ctrl.sv
// Scoreboard bench for cal_ctrl: expected output vectors are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_cal_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, sec_z, min_z, hr_z, day_z;
    logic [6:0] mon_in, day_in;
    logic       set_time, set_date, min_adv, hr_adv, day_adv, mon_adv;
    logic       sec_en, min_en, hr_en, day_en, mon_en, sec_clr, day_clr;
    logic [1:0] mode;

    // Output vector: {mode[1:0], sec_en, min_en, hr_en, day_en, mon_en, sec_clr, day_clr}
    localparam logic [8:0] ZERO   = 9'h000;
    localparam logic [8:0] SEC    = 9'h040;
    localparam logic [8:0] MIN    = 9'h020;
    localparam logic [8:0] HR     = 9'h010;
    localparam logic [8:0] DAY    = 9'h008;
    localparam logic [8:0] MON    = 9'h004;
    localparam logic [8:0] S_TIME = 9'h082;
    localparam logic [8:0] S_DATE = 9'h100;

    typedef struct {
        string      name;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cal_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .sec_z(sec_z), .min_z(min_z), .hr_z(hr_z), .day_z(day_z),
        .mon_in(mon_in), .day_in(day_in),
        .set_time(set_time), .set_date(set_date),
        .min_adv(min_adv), .hr_adv(hr_adv), .day_adv(day_adv), .mon_adv(mon_adv),
        .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en), .day_en(day_en), .mon_en(mon_en),
        .sec_clr(sec_clr), .day_clr(day_clr), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {mode, sec_en, min_en, hr_en, day_en, mon_en, sec_clr, day_clr};
    endfunction

    // Advance n cycles without checking (lets synchronizers settle).
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; tick = 1'b1; sec_z = 1'b1;
        sb.push_back('{name: "reset_hold0", val: ZERO});
        sb.push_back('{name: "reset_hold1", val: ZERO});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        rst = 1'b1; tick = 1'b0; sec_z = 1'b0;
        sb.push_back('{name: "reset_release", val: ZERO});
        @(negedge clk); #1;
        e = sb.pop_front(); n_tests++;
        if (outs() !== e.val) begin
            n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
        end
    endtask

    // Table of {tick,sec_z,min_z,hr_z,day_z} against the run-mode cascade.
    task automatic test_run_cascade();
        exp_t e;
        logic [4:0] stim [6];
        stim = '{5'b10000, 5'b00000, 5'b11111, 5'b11011, 5'b11101, 5'b01111};
        sb.push_back('{name: "tick_only",   val: SEC});
        sb.push_back('{name: "tick_low",    val: ZERO});
        sb.push_back('{name: "carry_all",   val: SEC | MIN | HR | DAY | MON});
        sb.push_back('{name: "carry_min0",  val: SEC | MIN});
        sb.push_back('{name: "carry_hr0",   val: SEC | MIN | HR});
        sb.push_back('{name: "z_no_tick",   val: ZERO});
        for (int i = 0; i < 6; i++) begin
            {tick, sec_z, min_z, hr_z, day_z} = stim[i];
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        {tick, sec_z, min_z, hr_z, day_z} = 5'b0;
    endtask

    task automatic test_set_time();
        exp_t e;
        set_time = 1'b1;
        sb.push_back('{name: "st_sync0", val: ZERO});
        sb.push_back('{name: "st_sync1", val: ZERO});
        sb.push_back('{name: "st_enter", val: S_TIME});
        sb.push_back('{name: "st_tick_ignored", val: S_TIME});
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin tick = 1'b1; sec_z = 1'b1; min_z = 1'b1; end
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        tick = 1'b0; sec_z = 1'b0; min_z = 1'b0;

        // hr_adv held 5 cycles: one pulse, acted on at the 2nd edge after first sample
        hr_adv = 1'b1;
        sb.push_back('{name: "hr_adv_c0", val: S_TIME});
        sb.push_back('{name: "hr_adv_c1", val: S_TIME | HR});
        sb.push_back('{name: "hr_adv_c2", val: S_TIME});
        sb.push_back('{name: "hr_adv_c3", val: S_TIME});
        sb.push_back('{name: "hr_adv_c4", val: S_TIME});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        hr_adv = 1'b0;
        idle(3);

        min_adv = 1'b1;
        sb.push_back('{name: "min_adv_c0", val: S_TIME});
        sb.push_back('{name: "min_adv_c1", val: S_TIME | MIN});
        sb.push_back('{name: "min_adv_c2", val: S_TIME});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        min_adv = 1'b0;
        idle(3);

        // Leave set mode and resume the cascade on the next tick
        set_time = 1'b0;
        sb.push_back('{name: "st_exit0", val: S_TIME});
        sb.push_back('{name: "st_exit1", val: S_TIME});
        sb.push_back('{name: "st_exit_run", val: ZERO});
        sb.push_back('{name: "resume_tick", val: SEC});
        for (int i = 0; i < 4; i++) begin
            if (i == 3) tick = 1'b1;
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        tick = 1'b0;
    endtask

    task automatic enter_set_date();
        exp_t e;
        set_date = 1'b1;
        sb.push_back('{name: "sd_sync0", val: ZERO});
        sb.push_back('{name: "sd_sync1", val: ZERO});
        sb.push_back('{name: "sd_enter", val: S_DATE});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
    endtask

    // Month advance from SET_DATE, new month m appears, clamp of day d checked.
    task automatic do_clamp(input string nm, input logic [6:0] m, input logic [6:0] d,
                            input logic clr);
        exp_t e;
        sb.push_back('{name: {nm, "_wait"},   val: S_DATE});
        sb.push_back('{name: {nm, "_mon_en"}, val: S_DATE | MON});
        sb.push_back('{name: {nm, "_clamp"},  val: {2'b11, 6'b0, clr}});
        sb.push_back('{name: {nm, "_back"},   val: S_DATE});
        day_in = d; mon_adv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
            if (i == 1) mon_in = m;
        end
        mon_adv = 1'b0;
        idle(3);
    endtask

    task automatic test_clamp();
        enter_set_date();
        mon_in = 7'd0;
        do_clamp("clamp_feb30", 7'd1,  7'd30, 1'b1);
        do_clamp("clamp_mar27", 7'd2,  7'd27, 1'b0);
        do_clamp("clamp_feb27", 7'd1,  7'd27, 1'b0);
        do_clamp("clamp_feb28", 7'd1,  7'd28, 1'b1);
        do_clamp("clamp_apr29", 7'd3,  7'd29, 1'b0);
        do_clamp("clamp_apr30", 7'd3,  7'd30, 1'b1);
        do_clamp("clamp_nov30", 7'd10, 7'd30, 1'b1);
        do_clamp("clamp_dec30", 7'd11, 7'd30, 1'b0);
        do_clamp("clamp_m12",   7'd12, 7'd30, 1'b0);
    endtask

    task automatic test_day_collision();
        exp_t e;
        day_adv = 1'b1;
        sb.push_back('{name: "day_adv_c0", val: S_DATE});
        sb.push_back('{name: "day_adv_c1", val: S_DATE | DAY});
        sb.push_back('{name: "day_adv_c2", val: S_DATE});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        day_adv = 1'b0;
        idle(3);

        mon_in = 7'd4; day_in = 7'd10;
        day_adv = 1'b1; mon_adv = 1'b1;
        sb.push_back('{name: "coll_wait",  val: S_DATE});
        sb.push_back('{name: "coll_mon",   val: S_DATE | MON});
        sb.push_back('{name: "coll_clamp", val: 9'h180});
        sb.push_back('{name: "coll_back",  val: S_DATE});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        day_adv = 1'b0; mon_adv = 1'b0;
        idle(3);
    endtask

    task automatic test_priority();
        exp_t e;
        set_time = 1'b1;
        sb.push_back('{name: "prio_s0",  val: S_DATE});
        sb.push_back('{name: "prio_s1",  val: S_DATE});
        sb.push_back('{name: "prio_time", val: S_TIME});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        set_time = 1'b0;
        sb.push_back('{name: "prio_r0",  val: S_TIME});
        sb.push_back('{name: "prio_r1",  val: S_TIME});
        sb.push_back('{name: "prio_date", val: S_DATE});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        mon_in = 7'd0; day_in = 7'd30; mon_adv = 1'b1;
        sb.push_back('{name: "ar_wait",  val: S_DATE});
        sb.push_back('{name: "ar_mon",   val: S_DATE | MON});
        sb.push_back('{name: "ar_clamp", val: 9'h181});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
            if (i == 1) mon_in = 7'd1;
        end
        // Mid-cycle reset: outputs must drop before any clock edge
        #2 rst = 1'b0;
        sb.push_back('{name: "ar_immediate", val: ZERO});
        #1;
        e = sb.pop_front(); n_tests++;
        if (outs() !== e.val) begin
            n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
        end
        @(negedge clk); #1;
        // Release with mon_adv and set_date still held: mode returns, no month pulse
        rst = 1'b1;
        sb.push_back('{name: "ar_rel0", val: ZERO});
        sb.push_back('{name: "ar_rel1", val: ZERO});
        for (int i = 2; i < 7; i++)
            sb.push_back('{name: $sformatf("ar_held_%0d", i), val: S_DATE});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            e = sb.pop_front(); n_tests++;
            if (outs() !== e.val) begin
                n_fail++; $display("FAIL %s: got %b want %b", e.name, outs(), e.val);
            end
        end
        mon_adv = 1'b0; set_date = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {tick, sec_z, min_z, hr_z, day_z} = 5'b0;
        mon_in = 7'd0; day_in = 7'd0;
        {set_time, set_date, min_adv, hr_adv, day_adv, mon_adv} = 6'b0;

        test_reset();
        test_run_cascade();
        test_set_time();
        test_clamp();
        test_day_collision();
        test_priority();
        test_async_reset();

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
